// File: rtl/aes128_req_scheduler.sv
// aes128_req_scheduler
// Shares one pipelined AES-128 core between NREQ requesters. Blocks are granted
// round-robin, registered onto the core inputs, and tracked by a tag pipeline
// that matches the core latency so each result leaves tagged with its requester.
// Build option: define AES_SCHED_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer); leave it undefined for round-robin arbitration.
module aes128_req_scheduler #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 21
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    drain,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*128-1:0]     req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic [127:0]            key,
    output logic [127:0]            core_plaintext,
    output logic [127:0]            core_key,
    input  logic [127:0]            core_ciphertext,
    output logic                    out_valid,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic [127:0]            out_data,
    output logic                    busy,
    output logic                    drained
);
    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  start_idx;
    logic [IDW-1:0]  arb_idx;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic            accept;
    logic [127:0]    sel_data;
    logic [127:0]    pt_q, key_q;
    logic            core_vld_q;
    logic [IDW-1:0]  core_id_q;
    logic            tag_vld_q [LATENCY];
    logic [IDW-1:0]  tag_id_q  [LATENCY];
    logic [CNTW-1:0] cnt_q, cnt_d;

`ifndef AES_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0]  ptr_q, ptr_d;

    assign start_idx = ptr_q;

    // Next search start is one past the requester that just transferred
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start_idx = '0;
`endif

    // Pick the first valid requester scanning upward from the start index
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        arb_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = IDW'((int'(start_idx) + k) % NREQ);
            if (!gnt_any && req_valid[arb_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = arb_idx;
            end
        end
    end

    // Grant only in RUN; a drain request in the same cycle suppresses acceptance
    always_comb begin
        req_ready = '0;
        if (state_q == S_RUN && !drain && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Grants go only to valid requesters, so any grant is a transfer
    assign accept = |req_ready;

    // Steer the granted requester's block toward the core input register
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_data = req_data[i*128 +: 128];
            end
        end
    end

    // Blocks sitting in the core: counted from presentation until retirement
    assign cnt_d = cnt_q + CNTW'(core_vld_q) - CNTW'(out_valid);

    // FSM next state; drained fires in the cycle the last in-flight result leaves
    always_comb begin
        state_d = state_q;
        drained = 1'b0;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (drain) state_d = S_DRAIN;
            S_DRAIN: begin
                if (!core_vld_q && cnt_d == '0) begin
                    state_d = S_IDLE;
                    drained = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: FSM, core-stage tag and in-flight count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            core_vld_q <= 1'b0;
            core_id_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            core_vld_q <= accept;
            if (accept) begin
                core_id_q <= gnt_idx;
            end
            cnt_q      <= cnt_d;
        end
    end

    // Core input registers load only on an accepted transfer and hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt_q  <= '0;
            key_q <= '0;
        end else if (accept) begin
            pt_q  <= sel_data;
            key_q <= key;
        end
    end

    // Tag pipeline trailing the core input stage by exactly the core latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
            end
        end else begin
            tag_vld_q[0] <= core_vld_q;
            tag_id_q[0]  <= core_id_q;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign core_plaintext = pt_q;
    assign core_key       = key_q;
    assign out_valid      = tag_vld_q[LATENCY-1];
    assign out_id         = tag_id_q[LATENCY-1];
    // Gate the raw core output so stale pipeline contents never appear as data
    assign out_data       = out_valid ? core_ciphertext : '0;
    // A freshly accepted block is in flight while in the core input register too
    assign busy           = (cnt_q != '0) | core_vld_q;

endmodule
